fifo_read_stream_adapter: RTL and testbench



---
 rtl/fifo_read_stream_adapter_pkg.sv | 14 +
 rtl/small_sync_fifo.sv | 54 +++++
 rtl/fifo_read_stream_adapter.sv | 107 ++++++++++
 tb/tb_fifo_read_stream_adapter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_stream_adapter_pkg.sv
// Shared sizing helpers for fifo_read_stream_adapter and its local buffer.
package fifo_read_stream_adapter_pkg;

    // Every in-flight read plus the word just landing needs a slot.
    function automatic int minBufDepth(input int readLatency);
        return readLatency + 1;
    endfunction

    // Occupancy/credit counters must represent the full depth, hence one extra bit.
    function automatic int cntWidth(input int bufDepthLog2);
        return bufDepthLog2 + 1;
    endfunction

endpackage

// File: rtl/small_sync_fifo.sv
// Register-based circular buffer with push/pop and occupancy; head word is always presented.
module small_sync_fifo
    import fifo_read_stream_adapter_pkg::*;
#(
    parameter int WIDTH      = 160,
    parameter int DEPTH_LOG2 = 2,
    localparam int CNT_W     = cntWidth(DEPTH_LOG2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic [CNT_W-1:0] occ,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic                  doPush;
    logic                  doPop;

    assign empty    = (occ == '0);
    assign full     = (occ == CNT_W'(DEPTH));
    assign doPop    = pop && !empty;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign doPush   = push && (!full || doPop);
    assign headData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            occ   <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + DEPTH_LOG2'(1);
            if (doPop)  rdPtr <= rdPtr + DEPTH_LOG2'(1);
            case ({doPush, doPop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/fifo_read_stream_adapter.sv
// Credit-based read side of the dual-clock FIFO, re-presented as a valid/ready stream.
// Optional FIFO_READ_ADAPTER_ECC_CHECK_EN makes eccError latch fifoEccStatus; otherwise it is tied low.
module fifo_read_stream_adapter
    import fifo_read_stream_adapter_pkg::*;
#(
    parameter int WIDTH          = 160,
    parameter int BUF_DEPTH_LOG2 = 2,
    parameter int READ_LATENCY   = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifoReadEnable,
    input  logic             fifoDataOutValid,
    input  logic [WIDTH-1:0] fifoDataOut,
    input  logic             fifoEccStatus,
    output logic             outValid,
    output logic [WIDTH-1:0] outData,
    input  logic             outReady,
    output logic             eccError,
    output logic             overflowError
);
    localparam int DEPTH = 2 ** BUF_DEPTH_LOG2;
    localparam int CNT_W = cntWidth(BUF_DEPTH_LOG2);
    localparam int SUM_W = CNT_W + 1;

    if (READ_LATENCY < 1) begin : gLatencyCheck
        $error("fifo_read_stream_adapter: READ_LATENCY must be at least 1");
    end
    if (DEPTH < minBufDepth(READ_LATENCY)) begin : gDepthCheck
        $error("fifo_read_stream_adapter: buffer too shallow for READ_LATENCY");
    end

    logic [READ_LATENCY-1:0] inflight;
    logic [READ_LATENCY-1:0] inflightNext;
    logic [CNT_W-1:0]        nInflight;
    logic [CNT_W-1:0]        occ;
    logic [SUM_W-1:0]        committed;
    logic                    issue;
    logic                    inflightTail;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;

    // Only registered state feeds the credit check; a same-cycle pop earns no credit.
    assign committed      = SUM_W'(occ) + SUM_W'(nInflight);
    assign issue          = !rst && (committed < SUM_W'(DEPTH));
    assign fifoReadEnable = issue;

    assign inflightTail = inflight[READ_LATENCY-1];
    assign push         = fifoDataOutValid && !rst;
    assign pop          = outValid && outReady;
    assign outValid     = !empty;

    if (READ_LATENCY == 1) begin : gShift1
        assign inflightNext = issue;
    end else begin : gShiftN
        assign inflightNext = {inflight[READ_LATENCY-2:0], issue};
    end

    // A request retires when it leaves the tail, even if the FIFO had nothing to return.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= '0;
            nInflight <= '0;
        end else begin
            inflight <= inflightNext;
            case ({issue, inflightTail})
                2'b10:   nInflight <= nInflight + CNT_W'(1);
                2'b01:   nInflight <= nInflight - CNT_W'(1);
                default: nInflight <= nInflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                        overflowError <= 1'b0;
        else if (push && full && !pop)  overflowError <= 1'b1;
    end

`ifdef FIFO_READ_ADAPTER_ECC_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)                                     eccError <= 1'b0;
        else if (fifoDataOutValid && fifoEccStatus)  eccError <= 1'b1;
    end
`else
    logic unusedEccStatus;
    assign unusedEccStatus = fifoEccStatus;
    assign eccError        = 1'b0;
`endif

    small_sync_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (BUF_DEPTH_LOG2)
    ) uBuf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pushData (fifoDataOut),
        .pop      (pop),
        .headData (outData),
        .occ      (occ),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Bench: hand table plus scripted/random streams against a queue-level model, latency 1 and 3 instances.
module tb_fifo_read_stream_adapter;
    localparam int W     = 160;
    localparam int DEPTH = 4;
`ifdef FIFO_READ_ADAPTER_ECC_CHECK_EN
    localparam bit ECC_ON = 1'b1;
`else
    localparam bit ECC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst    [2];
    logic         fre    [2];
    logic         fdv    [2];
    logic [W-1:0] fd     [2];
    logic         ecc    [2];
    logic         ov     [2];
    logic [W-1:0] od     [2];
    logic         rdy    [2];
    logic         eccErr [2];
    logic         ovf    [2];

    fifo_read_stream_adapter #(.WIDTH(W), .BUF_DEPTH_LOG2(2), .READ_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst[0]), .fifoReadEnable(fre[0]), .fifoDataOutValid(fdv[0]),
        .fifoDataOut(fd[0]), .fifoEccStatus(ecc[0]), .outValid(ov[0]), .outData(od[0]),
        .outReady(rdy[0]), .eccError(eccErr[0]), .overflowError(ovf[0]));

    fifo_read_stream_adapter #(.WIDTH(W), .BUF_DEPTH_LOG2(2), .READ_LATENCY(3)) dut1 (
        .clk(clk), .rst(rst[1]), .fifoReadEnable(fre[1]), .fifoDataOutValid(fdv[1]),
        .fifoDataOut(fd[1]), .fifoEccStatus(ecc[1]), .outValid(ov[1]), .outData(od[1]),
        .outReady(rdy[1]), .eccError(eccErr[1]), .overflowError(ovf[1]));

    typedef struct {
        bit r; bit v; int d; bit e; bit rdy;
        bit xFre; bit xOv; int xD; bit xOvf; bit xEcc;
    } vec_t;
    vec_t tab [17];
    int   tabRow = -1;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: buffer contents as a list, plus issue history per clock edge.
    int           lat [2];
    logic [W-1:0] mBuf [2][DEPTH];
    int           mCnt [2];
    bit           mOvf [2];
    bit           mEcc [2];
    int           hist [2][8];
    int           edgeNo = 8;
    int           cyc = 0;
    bit           modelChk [2];

    // Source FIFO emulation.
    bit direct [2];
    bit gapOn  [2];
    int srcNext [2];
    int srcEnd  [2];
    bit retV [2][4];
    int retI [2][4];
    int eccIdx [2];

    int beats [2];
    int firstBeat [2];
    int lastBeat [2];
    int freCnt [2];
    bit ordChk [2];
    int ordNext [2];

    function automatic logic [W-1:0] mkWord(input int idx);
        logic [31:0] v;
        v = idx[31:0];
        return {~v, v ^ 32'hA5A5_0000, ~v, v, v ^ 32'h0000_5A5A};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        bit           hs [2];
        bit           dIss [2];
        bit           sV [2];
        bit           sE [2];
        bit           sR [2];
        logic [W-1:0] sD [2];
        bit           gap;
        bit           got;
        int           pend;
        bit           xFre;
        bit           xOv;
        #3;
        if (tabRow >= 0) begin
            check($sformatf("tab%0d.fre", tabRow), W'(fre[0]), W'(tab[tabRow].xFre));
            check($sformatf("tab%0d.ov", tabRow), W'(ov[0]), W'(tab[tabRow].xOv));
            if (tab[tabRow].xOv)
                check($sformatf("tab%0d.data", tabRow), od[0], mkWord(tab[tabRow].xD));
            check($sformatf("tab%0d.ovf", tabRow), W'(ovf[0]), W'(tab[tabRow].xOvf));
            check($sformatf("tab%0d.ecc", tabRow), W'(eccErr[0]), W'(tab[tabRow].xEcc));
        end
        for (int k = 0; k < 2; k++) begin
            pend = 0;
            for (int j = 0; j < lat[k]; j++) pend += hist[k][(edgeNo - j) & 7];
            xFre = !rst[k] && (mCnt[k] + pend < DEPTH);
            xOv  = (mCnt[k] != 0);
            if (modelChk[k]) begin
                check($sformatf("m%0d.fre@%0d", k, cyc), W'(fre[k]), W'(xFre));
                check($sformatf("m%0d.ov@%0d", k, cyc), W'(ov[k]), W'(xOv));
                if (xOv) check($sformatf("m%0d.data@%0d", k, cyc), od[k], mBuf[k][0]);
                check($sformatf("m%0d.ovf@%0d", k, cyc), W'(ovf[k]), W'(mOvf[k]));
                check($sformatf("m%0d.ecc@%0d", k, cyc), W'(eccErr[k]), W'(mEcc[k]));
            end
            hs[k]   = xOv && (rdy[k] === 1'b1);
            dIss[k] = (fre[k] === 1'b1);
            sV[k]   = (fdv[k] === 1'b1);
            sE[k]   = (ecc[k] === 1'b1);
            sR[k]   = (rst[k] === 1'b1);
            sD[k]   = fd[k];
            if (dIss[k]) freCnt[k]++;
            if (hs[k]) begin
                if (beats[k] == 0) firstBeat[k] = cyc;
                lastBeat[k] = cyc;
                beats[k]++;
                if (ordChk[k]) begin
                    check($sformatf("order%0d.word%0d", k, ordNext[k]), od[k], mkWord(ordNext[k]));
                    ordNext[k]++;
                end
            end
            hist[k][(edgeNo + 1) & 7] = xFre ? 1 : 0;
        end
        @(posedge clk);
        edgeNo++;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (sR[k]) begin
                mCnt[k] = 0;
                mOvf[k] = 1'b0;
                mEcc[k] = 1'b0;
                for (int j = 0; j < 8; j++) hist[k][j] = 0;
            end else begin
                if (hs[k]) begin
                    for (int j = 0; j < DEPTH - 1; j++) mBuf[k][j] = mBuf[k][j+1];
                    mCnt[k]--;
                end
                if (sV[k]) begin
                    if (mCnt[k] < DEPTH) begin
                        mBuf[k][mCnt[k]] = sD[k];
                        mCnt[k]++;
                    end else begin
                        mOvf[k] = 1'b1;
                    end
                    if (sE[k] && ECC_ON) mEcc[k] = 1'b1;
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++)
                if (j < lat[k] - 1) begin
                    retV[k][j] = retV[k][j+1];
                    retI[k][j] = retI[k][j+1];
                end
            gap = gapOn[k] && ($urandom_range(0, 3) == 0);
            got = dIss[k] && !sR[k] && (srcNext[k] < srcEnd[k]) && !gap;
            retV[k][lat[k]-1] = got;
            retI[k][lat[k]-1] = srcNext[k];
            if (got) srcNext[k]++;
            if (sR[k]) begin
                for (int j = 0; j < 4; j++) retV[k][j] = 1'b0;
                srcNext[k] = srcEnd[k];
            end
            if (!direct[k]) begin
                fdv[k] = retV[k][0];
                fd[k]  = retV[k][0] ? mkWord(retI[k][0]) : '0;
                ecc[k] = retV[k][0] && (retI[k][0] == eccIdx[k]);
            end
        end
    endtask

    task automatic doReset(input int k, input int n);
        rst[k] = 1'b1;
        repeat (n) tick();
        rst[k] = 1'b0;
    endtask

    task automatic load(input int k, input int base, input int n);
        srcNext[k] = base;
        srcEnd[k]  = base + n;
        ordNext[k] = base;
        ordChk[k]  = 1'b1;
        beats[k]   = 0;
    endtask

    initial begin
        lat[0] = 1;
        lat[1] = 3;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; fdv[k] = 1'b0; fd[k] = '0; ecc[k] = 1'b0; rdy[k] = 1'b0;
            mCnt[k] = 0; mOvf[k] = 1'b0; mEcc[k] = 1'b0; modelChk[k] = 1'b0;
            direct[k] = 1'b0; gapOn[k] = 1'b0; srcNext[k] = 0; srcEnd[k] = 0;
            eccIdx[k] = -1; beats[k] = 0; firstBeat[k] = 0; lastBeat[k] = 0;
            freCnt[k] = 0; ordChk[k] = 1'b0; ordNext[k] = 0;
            for (int j = 0; j < 8; j++) hist[k][j] = 0;
            for (int j = 0; j < 4; j++) begin retV[k][j] = 1'b0; retI[k][j] = 0; end
        end

        //            r  v  d  e rdy fre ov xD ovf  ecc
        tab[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 1'b0};
        tab[1]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 1'b0};
        tab[2]  = '{0, 1, 1, 0, 0,  1, 0, 0, 0, 1'b0};
        tab[3]  = '{0, 1, 2, 0, 0,  1, 1, 1, 0, 1'b0};
        tab[4]  = '{0, 1, 3, 0, 0,  1, 1, 1, 0, 1'b0};
        tab[5]  = '{0, 1, 4, 0, 0,  0, 1, 1, 0, 1'b0};
        tab[6]  = '{0, 0, 0, 0, 0,  0, 1, 1, 0, 1'b0};
        tab[7]  = '{0, 1, 99, 1, 0, 0, 1, 1, 0, 1'b0};
        tab[8]  = '{0, 0, 0, 0, 1,  0, 1, 1, 1, ECC_ON};
        tab[9]  = '{0, 0, 0, 0, 1,  1, 1, 2, 1, ECC_ON};
        tab[10] = '{0, 1, 5, 0, 0,  1, 1, 3, 1, ECC_ON};
        tab[11] = '{0, 0, 0, 0, 1,  0, 1, 3, 1, ECC_ON};
        tab[12] = '{0, 0, 0, 0, 1,  1, 1, 4, 1, ECC_ON};
        tab[13] = '{0, 0, 0, 0, 1,  1, 1, 5, 1, ECC_ON};
        tab[14] = '{0, 0, 0, 0, 1,  1, 0, 0, 1, ECC_ON};
        tab[15] = '{1, 0, 0, 0, 1,  0, 0, 0, 1, ECC_ON};
        tab[16] = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 1'b0};

        repeat (2) tick();
        modelChk[0] = 1'b1;
        modelChk[1] = 1'b1;
        rst[1] = 1'b0;

        // Direct-drive table on the latency-1 instance, including an injected overflow.
        direct[0] = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rst[0] = tab[i].r; fdv[0] = tab[i].v; fd[0] = mkWord(tab[i].d);
            ecc[0] = tab[i].e; rdy[0] = tab[i].rdy;
            tabRow = i;
            tick();
        end
        tabRow = -1;
        direct[0] = 1'b0;
        fdv[0] = 1'b0;
        ecc[0] = 1'b0;

        // Streaming 20 words with word 5 flagged by ECC.
        doReset(0, 2);
        load(0, 0, 20);
        eccIdx[0] = 5;
        rdy[0] = 1'b1;
        for (int t = 0; t < 60 && beats[0] < 20; t++) tick();
        check("stream.beats", W'(beats[0]), W'(20));
        check("stream.consecutive", W'(lastBeat[0] - firstBeat[0]), W'(19));
        repeat (3) tick();
        check("stream.freIdle", W'(fre[0]), W'(1));
        check("stream.eccSticky", W'(eccErr[0]), W'(ECC_ON));
        eccIdx[0] = -1;
        doReset(0, 1);
        check("stream.eccCleared", W'(eccErr[0]), W'(0));

        // Backpressure: exactly four reads issued while stalled.
        doReset(0, 2);
        load(0, 0, 20);
        rdy[0] = 1'b0;
        freCnt[0] = 0;
        repeat (10) tick();
        check("bp.issued", W'(freCnt[0]), W'(4));
        check("bp.ov", W'(ov[0]), W'(1));
        check("bp.ovf", W'(ovf[0]), W'(0));
        rdy[0] = 1'b1;
        for (int t = 0; t < 80 && beats[0] < 20; t++) tick();
        check("bp.beats", W'(beats[0]), W'(20));

        // Latency 3 with outReady toggling every cycle.
        doReset(1, 2);
        load(1, 0, 50);
        for (int t = 0; t < 400 && beats[1] < 50; t++) begin
            rdy[1] = t[0];
            tick();
        end
        check("lat3.beats", W'(beats[1]), W'(50));
        check("lat3.ovf", W'(ovf[1]), W'(0));
        rdy[1] = 1'b0;

        // Reset in the middle of traffic with three words held.
        doReset(0, 2);
        load(0, 0, 10);
        rdy[0] = 1'b0;
        for (int t = 0; t < 10 && mCnt[0] != 3; t++) tick();
        check("midrst.occ3", W'(ov[0]), W'(1));
        rst[0] = 1'b1;
        tick();
        check("midrst.ov", W'(ov[0]), W'(0));
        tick();
        rst[0] = 1'b0;
        #1;
        check("midrst.freResume", W'(fre[0]), W'(1));
        check("midrst.ovf", W'(ovf[0]), W'(0));
        load(0, 100, 5);
        rdy[0] = 1'b1;
        for (int t = 0; t < 30 && beats[0] < 5; t++) tick();
        check("midrst.beats", W'(beats[0]), W'(5));

        // Random backpressure and source gaps on both instances.
        doReset(0, 1);
        doReset(1, 1);
        load(0, 200, 60);
        load(1, 300, 60);
        gapOn[0] = 1'b1;
        gapOn[1] = 1'b1;
        for (int t = 0; t < 1000 && (beats[0] < 60 || beats[1] < 60); t++) begin
            rdy[0] = ($urandom_range(0, 9) < 7);
            rdy[1] = ($urandom_range(0, 9) < 6);
            tick();
        end
        check("rand0.beats", W'(beats[0]), W'(60));
        check("rand1.beats", W'(beats[1]), W'(60));
        check("rand1.ovf", W'(ovf[1]), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
